aes_rx_block_assembler: RTL and testbench
=========================================

Name: aes_rx_block_assembler

Overview:
- Upstream feeder for the combinational AES-128 encipher core in the UART datapath.
- Collects bytes from the UART receiver and assembles a 128-bit key followed by a 128-bit plaintext.
- Presents both words with a valid/ready handshake, and holds them stable while the cipher core output is consumed.
- Discards stale partial frames with an inter-byte timeout.

Parameters:
- TIMEOUT_CYCLES, 100000: number of consecutive idle clk cycles during a frame in progress that aborts the frame. 0 disables the timeout.
- TMR_W, 17: width of the idle counter. Must satisfy 2^TMR_W > TIMEOUT_CYCLES.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- rx_data  input  8  byte from UART receiver
- rx_valid  input  1  one-cycle strobe: rx_data valid
- key_text  output  128  assembled key, to encipher key_text
- plain_text  output  128  assembled plaintext, to encipher plain_text
- blk_valid  output  1  key_text/plain_text complete and stable
- blk_ready  input  1  consumer has captured cipher_text
- err_timeout  output  1  one-cycle pulse: partial frame discarded
- err_overrun  output  1  one-cycle pulse: byte dropped while holding

Behaviour:
- Reset (async, rst_n=0) values:
  - state=S_KEY, cnt=0, idle timer=0
  - key_text=0, plain_text=0
  - blk_valid=0, err_timeout=0, err_overrun=0
- Byte order: first received byte lands in bits [127:120] and the 16th in [7:0]. Each accepted byte shifts the word: word <= {word[119:0], rx_data}.
- cnt is 4 bits and counts accepted bytes in the current word.
- S_KEY:
  - rx_valid shifts into key_text and increments cnt.
  - On the 16th byte (cnt==15): go to S_TEXT, cnt wraps to 0.
- S_TEXT:
  - rx_valid shifts into plain_text.
  - On the 16th byte: go to S_HOLD, cnt to 0.
  - blk_valid=1 from the next cycle, i.e. 1 cycle after the last byte strobe.
- S_HOLD:
  - blk_valid=1. key_text and plain_text do not change.
  - Handshake: blk_valid & blk_ready at a rising edge. Next state is S_KEY; blk_valid=0 the following cycle.
  - blk_ready while not in S_HOLD is ignored.
- Overrun:
  - rx_valid in S_HOLD, including the handshake cycle, drops the byte and pulses err_overrun for 1 cycle.
  - The outputs are unaffected.
- Outputs are registered. key_text and plain_text visibly shift during collection; they are only meaningful while blk_valid=1.
- Timeout:
  - The idle timer increments each cycle without rx_valid while a frame is in progress, meaning S_KEY with cnt>0, or S_TEXT.
  - The timer clears on any accepted byte and is held at 0 in S_HOLD and in S_KEY with cnt==0.
  - When the timer reaches TIMEOUT_CYCLES: state goes to S_KEY, cnt=0, timer=0, err_timeout pulses 1 cycle. key_text/plain_text keep their stale contents.
  - rx_valid on the expiry cycle wins: the byte is accepted and the timer clears, with no timeout.
- Reset asserted mid-frame or in S_HOLD immediately forces all reset values, dropping blk_valid asynchronously.
- err_timeout and err_overrun never assert in the same cycle (they occur in disjoint states).

Optional Feature:
- Macro: AES_RX_KEY_REUSE_EN.
- Defined:
  - After a handshake in S_HOLD the next state is S_TEXT, with key_text retained, so subsequent blocks need only 16 plaintext bytes.
  - The idle timer is held at 0 in S_TEXT with cnt==0 when it was entered via handshake (key-ready idle).
  - It runs normally once a plaintext byte arrives, and S_TEXT entered from S_KEY still times out at cnt==0.
  - A timeout still returns to S_KEY; the host resynchronises with a full key+plaintext frame.
- Undefined: every block requires key then plaintext (32 bytes), and handshake returns to S_KEY.

Test Plan:
- Basic frame, FIPS-197 vector:
  - Stimulus: send key bytes 00,01,…,0f, then plaintext 00,11,22,…,ff, with blk_ready=0.
  - Required: blk_valid=1 exactly 1 cycle after the 32nd strobe, key_text=000102030405060708090a0b0c0d0e0f, plain_text=00112233445566778899aabbccddeeff. The downstream cipher equals 69c4e0d86a7b0430d8cdb78070b4c55a.
- Hold/handshake:
  - Stimulus: keep blk_ready=0 for 50 cycles, then pulse it for 1 cycle.
  - Required: outputs stable throughout, blk_valid=0 on the next cycle, state S_KEY (S_TEXT with AES_RX_KEY_REUSE_EN).
- Overrun:
  - Stimulus: send 3 bytes during S_HOLD, one of them on the handshake cycle.
  - Required: 3 err_overrun pulses, plain_text unchanged, no bytes counted in the next frame.
- Timeout (TIMEOUT_CYCLES=20):
  - Stimulus: send 5 key bytes, then idle.
  - Required: err_timeout pulses at idle cycle 20. A following full 32-byte frame assembles correctly. A byte arriving on idle cycle 20 instead suppresses the timeout.
- Reset mid-frame:
  - Stimulus: drop rst_n after 20 bytes, and again while blk_valid=1.
  - Required: all outputs 0 immediately. A subsequent 32-byte frame is correct.
- AES_RX_KEY_REUSE_EN:
  - Stimulus: send a 32-byte frame, handshake, then 16 bytes ff..f0.
  - Required: second block has the original key_text, plain_text=fffefdfcfbfaf9f8f7f6f5f4f3f2f1f0, and no timeout during the key-ready idle.

Source files
------------

// File: rtl/aes_rx_block_assembler.sv
// Byte-to-block assembler feeding the AES-128 encipher core: 16 key bytes then 16 plaintext bytes, held under valid/ready.
// Optional macro AES_RX_KEY_REUSE_EN keeps the key after a handshake so later blocks need only plaintext.
module aes_rx_block_assembler #(
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int TMR_W          = 17
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [7:0]   rx_data,
    input  logic         rx_valid,
    output logic [127:0] key_text,
    output logic [127:0] plain_text,
    output logic         blk_valid,
    input  logic         blk_ready,
    output logic         err_timeout,
    output logic         err_overrun
);

    typedef enum logic [1:0] {
        S_KEY  = 2'd0,
        S_TEXT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    localparam bit               TMO_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);

    state_t             state_r, state_s;
    logic [3:0]         cnt_r, cnt_s;
    logic [TMR_W-1:0]   tmr_r, tmr_s;
    logic [127:0]       key_r, key_s, plain_r, plain_s;
    logic               blk_valid_r;
    logic               err_timeout_r, err_timeout_s;
    logic               err_overrun_r, err_overrun_s;
    logic               tmr_run_s, expire_s;
`ifdef AES_RX_KEY_REUSE_EN
    logic               key_idle_r, key_idle_s;
`endif

    // Next-state, datapath shift and error pulse decode.
    always_comb begin
        state_s       = state_r;
        cnt_s         = cnt_r;
        tmr_s         = tmr_r;
        key_s         = key_r;
        plain_s       = plain_r;
        err_timeout_s = 1'b0;
        err_overrun_s = 1'b0;
`ifdef AES_RX_KEY_REUSE_EN
        key_idle_s    = key_idle_r;
`endif
        case (state_r)
            S_KEY:   tmr_run_s = (cnt_r != 4'd0);
`ifdef AES_RX_KEY_REUSE_EN
            S_TEXT:  tmr_run_s = !key_idle_r;
`else
            S_TEXT:  tmr_run_s = 1'b1;
`endif
            default: tmr_run_s = 1'b0;
        endcase
        expire_s = TMO_EN && tmr_run_s && !rx_valid && (tmr_r == TMO_LAST);

        case (state_r)
            S_KEY, S_TEXT: begin
                if (rx_valid) begin
                    cnt_s = cnt_r + 4'd1;
                    tmr_s = '0;
                    if (state_r == S_KEY) begin
                        key_s = {key_r[119:0], rx_data};
                    end else begin
                        plain_s = {plain_r[119:0], rx_data};
                    end
`ifdef AES_RX_KEY_REUSE_EN
                    key_idle_s = 1'b0;
`endif
                    if (cnt_r == 4'd15) begin
                        state_s = (state_r == S_KEY) ? S_TEXT : S_HOLD;
                    end else begin
                        state_s = state_r;
                    end
                end else if (expire_s) begin
                    // Stale partial frame: restart from the key, keep old word contents.
                    state_s       = S_KEY;
                    cnt_s         = 4'd0;
                    tmr_s         = '0;
                    err_timeout_s = 1'b1;
`ifdef AES_RX_KEY_REUSE_EN
                    key_idle_s    = 1'b0;
`endif
                end else if (tmr_run_s && TMO_EN) begin
                    tmr_s = tmr_r + TMR_ONE;
                end else begin
                    tmr_s = '0;
                end
            end
            S_HOLD: begin
                tmr_s         = '0;
                err_overrun_s = rx_valid;
                if (blk_ready) begin
                    cnt_s = 4'd0;
`ifdef AES_RX_KEY_REUSE_EN
                    state_s    = S_TEXT;
                    key_idle_s = 1'b1;
`else
                    state_s = S_KEY;
`endif
                end else begin
                    state_s = S_HOLD;
                end
            end
            default: begin
                state_s = S_KEY;
                cnt_s   = 4'd0;
                tmr_s   = '0;
            end
        endcase
    end

    // State and output registers; blk_valid tracks the registered hold state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= S_KEY;
            cnt_r         <= 4'd0;
            tmr_r         <= '0;
            key_r         <= 128'd0;
            plain_r       <= 128'd0;
            blk_valid_r   <= 1'b0;
            err_timeout_r <= 1'b0;
            err_overrun_r <= 1'b0;
`ifdef AES_RX_KEY_REUSE_EN
            key_idle_r    <= 1'b0;
`endif
        end else begin
            state_r       <= state_s;
            cnt_r         <= cnt_s;
            tmr_r         <= tmr_s;
            key_r         <= key_s;
            plain_r       <= plain_s;
            blk_valid_r   <= (state_s == S_HOLD);
            err_timeout_r <= err_timeout_s;
            err_overrun_r <= err_overrun_s;
`ifdef AES_RX_KEY_REUSE_EN
            key_idle_r    <= key_idle_s;
`endif
        end
    end

    assign key_text    = key_r;
    assign plain_text  = plain_r;
    assign blk_valid   = blk_valid_r;
    assign err_timeout = err_timeout_r;
    assign err_overrun = err_overrun_r;

endmodule

// File: tb/tb_aes_rx_block_assembler.sv
// Self-checking bench for aes_rx_block_assembler: frame table with scoreboard plus timeout, overrun and reset sequences.
module tb_aes_rx_block_assembler;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [7:0]   rx_data;
    logic         rx_valid;
    logic [127:0] key_text;
    logic [127:0] plain_text;
    logic         blk_valid;
    logic         blk_ready;
    logic         err_timeout;
    logic         err_overrun;

    aes_rx_block_assembler #(.TIMEOUT_CYCLES(20), .TMR_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
        .key_text(key_text), .plain_text(plain_text), .blk_valid(blk_valid),
        .blk_ready(blk_ready), .err_timeout(err_timeout), .err_overrun(err_overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] key;
        logic [127:0] plain;
    } vec_t;

    vec_t   sb[$];
    int     n_checks = 0;
    int     n_pass   = 0;
    int     n_tmo    = 0;
    int     n_ovr    = 0;
    bit     key_loaded = 1'b0;
    logic [127:0] last_key = 128'd0;

    // Pulse counters sampled on the falling edge.
    always @(negedge clk) begin
        if (err_timeout) n_tmo++;
        if (err_overrun) n_ovr++;
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [127:0] k, input logic [127:0] p,
                              input int gap_at, input int gap_len);
        logic [255:0] bytes;
        int           nb;
        vec_t         e;
        if (!key_loaded) begin
            last_key = k;
            bytes    = {k, p};
            nb       = 32;
        end else begin
            bytes = {p, 128'd0};
            nb    = 16;
        end
        e.key   = last_key;
        e.plain = p;
        sb.push_back(e);
        for (int i = 0; i < nb; i++) begin
            if (i == nb - 1) chk("valid_before_last", {127'd0, blk_valid}, 128'd0);
            send_byte(bytes[255 - 8*i -: 8]);
            if (i == gap_at) idle(gap_len);
        end
    endtask

    task automatic check_block();
        vec_t e;
        chk("blk_valid_latency", {127'd0, blk_valid}, 128'd1);
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 128'd1, 128'd0);
        end else begin
            e = sb.pop_front();
            chk("key_text", key_text, e.key);
            chk("plain_text", plain_text, e.plain);
        end
    endtask

    task automatic handshake(input logic with_byte);
        blk_ready = 1'b1;
        rx_valid  = with_byte;
        rx_data   = 8'h5a;
        @(posedge clk);
        #1;
        blk_ready = 1'b0;
        rx_valid  = 1'b0;
        chk("valid_after_handshake", {127'd0, blk_valid}, 128'd0);
`ifdef AES_RX_KEY_REUSE_EN
        key_loaded = 1'b1;
`endif
    endtask

    task automatic check_zero(input string name);
        chk({name, "_key"},   key_text, 128'd0);
        chk({name, "_plain"}, plain_text, 128'd0);
        chk({name, "_valid"}, {125'd0, blk_valid, err_timeout, err_overrun}, 128'd0);
    endtask

    vec_t vecs[4];

    initial begin
        int           t0;
        int           o0;
        bit           stable;
        logic [127:0] k_s, p_s;

        vecs[0].key = 128'h000102030405060708090a0b0c0d0e0f; vecs[0].plain = 128'h00112233445566778899aabbccddeeff;
        vecs[1].key = 128'hffffffffffffffffffffffffffffffff; vecs[1].plain = 128'h00000000000000000000000000000000;
        vecs[2].key = 128'h2b7e151628aed2a6abf7158809cf4f3c; vecs[2].plain = 128'h3243f6a8885a308d313198a2e0370734;
        vecs[3].key = 128'ha5a55a5a0f0ff0f0c3c33c3c96966969; vecs[3].plain = 128'hfffefdfcfbfaf9f8f7f6f5f4f3f2f1f0;

        rst_n = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; blk_ready = 1'b0;
        #12;
        check_zero("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(2);

        // Timeout after exactly 20 idle cycles with a partial key.
        for (int i = 0; i < 5; i++) send_byte(8'(i + 1));
        idle(19);
        chk("tmo_not_yet", {127'd0, err_timeout}, 128'd0);
        idle(1);
        chk("tmo_pulse", {127'd0, err_timeout}, 128'd1);
        idle(1);
        chk("tmo_one_cycle", {127'd0, err_timeout}, 128'd0);
        chk("tmo_count", 128'(n_tmo), 128'd1);

        // Full frame with a byte landing on idle cycle 20: no timeout.
        send_frame(vecs[2].key, vecs[2].plain, 4, 19);
        check_block();
        chk("tmo_suppressed", 128'(n_tmo), 128'd1);
        handshake(1'b0);

        // FIPS-197 frame, then hold 50 cycles.
        send_frame(vecs[0].key, vecs[0].plain, -1, 0);
        check_block();
        k_s = key_text; p_s = plain_text; stable = 1'b1;
        o0 = n_ovr;
        for (int c = 0; c < 50; c++) begin
            idle(1);
            if (key_text !== k_s || plain_text !== p_s || blk_valid !== 1'b1) stable = 1'b0;
        end
        chk("hold_stable", {127'd0, stable}, 128'd1);

        // Overrun: two bytes during hold and one on the handshake cycle.
        send_byte(8'h11);
        send_byte(8'h22);
        chk("overrun_plain", plain_text, p_s);
        chk("overrun_valid", {127'd0, blk_valid}, 128'd1);
        handshake(1'b1);
        idle(1);
        chk("overrun_count", 128'(n_ovr - o0), 128'd3);
        chk("overrun_plain_after", plain_text, p_s);

        // Frame table; each block must assemble exactly.
        for (int v = 0; v < 4; v++) begin
            send_frame(vecs[v].key, vecs[v].plain, -1, 0);
            check_block();
            handshake(1'b0);
        end

        // Long idle after handshake must not time out.
        t0 = n_tmo;
        idle(40);
        chk("key_ready_idle", 128'(n_tmo - t0), 128'd0);
        send_frame(vecs[1].key, 128'hfffefdfcfbfaf9f8f7f6f5f4f3f2f1f0, -1, 0);
        check_block();

        // Reset while blk_valid is high.
        #3;
        rst_n = 1'b0;
        #1;
        check_zero("rst_hold");
        @(posedge clk); #1;
        rst_n = 1'b1;
        key_loaded = 1'b0;
        idle(1);

        // Reset after 20 bytes of a frame.
        for (int i = 0; i < 20; i++) send_byte(8'(8'hc0 + i));
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("rst_mid");
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(1);
        send_frame(vecs[2].key, vecs[2].plain, -1, 0);
        check_block();
        chk("no_stray_errors", 128'(n_tmo), 128'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Absolute time bound in case a sequence stalls.
    initial begin
        #200000;
        $display("FAIL timeout_guard: simulation exceeded time bound");
        $fatal(1);
    end

endmodule
